// File: rtl/ac97_controller.sv
// AC'97 link-layer serializer: builds the 256-bit output frame (tag, command
// address/data, PCM left/right) and drives SYNC, SDATA_OUT and the codec reset.
module ac97_controller (
   input  logic        BIT_CLK,
   input  logic        SYSTEM_RESET,
   input  logic        SYSCLK,
   input  logic [19:0] PCM_LR,
   input  logic [19:0] CMD_ADDR,
   input  logic [19:0] CMD_DATA,
   input  logic        SDATA_IN,
   output logic [7:0]  count_reg,
   output logic        SYNC,
   output logic        SDATA_OUT,
   output logic        RESET
);

   localparam logic [15:0] TAG = 16'hF800;

   logic [7:0]  count_q,  count_d;
   logic        sync_q,   sync_d;
   logic        sdata_q,  sdata_d;
   logic        reset_q,  reset_d;
   logic [19:0] addr_q,   addr_d;
   logic [19:0] data_q,   data_d;
   logic [19:0] pcm_q,    pcm_d;

   // Inputs with no function here; named so lint treats them as intentionally unused.
   logic unused_inputs;
   assign unused_inputs = SYSCLK ^ SDATA_IN;

   // Frame bit n: tag, slot 1 address, slot 2 data, slots 3/4 PCM, rest zero.
   function automatic logic frame_bit(input logic [7:0] n, input logic [19:0] a,
                                      input logic [19:0] d, input logic [19:0] p);
      logic b;
      b = 1'b0;
      if (n < 8'd16) begin
         b = TAG[4'(8'd15 - n)];
      end else if (n < 8'd36) begin
         b = a[5'(8'd35 - n)];
      end else if (n < 8'd56) begin
         b = d[5'(8'd55 - n)];
      end else if (n < 8'd76) begin
         b = p[5'(8'd75 - n)];
      end else if (n < 8'd96) begin
         b = p[5'(8'd95 - n)];
      end else begin
         b = 1'b0;
      end
      return b;
   endfunction

   // Next-state: advance the bit counter, latch inputs at frame start, pick the next frame bit.
   always_comb begin
      count_d = count_q + 8'd1;
      reset_d = 1'b1;
      if (count_q == 8'd255) begin
         addr_d = CMD_ADDR;
         data_d = CMD_DATA;
         pcm_d  = PCM_LR;
      end else begin
         addr_d = addr_q;
         data_d = data_q;
         pcm_d  = pcm_q;
      end
      sync_d  = (count_d < 8'd16) ? 1'b1 : 1'b0;
      sdata_d = frame_bit(count_d, addr_d, data_d, pcm_d);
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge BIT_CLK) begin
      if (SYSTEM_RESET) begin
         count_q <= 8'd255;
         sync_q  <= 1'b0;
         sdata_q <= 1'b0;
         reset_q <= 1'b0;
         addr_q  <= 20'd0;
         data_q  <= 20'd0;
         pcm_q   <= 20'd0;
      end else begin
         count_q <= count_d;
         sync_q  <= sync_d;
         sdata_q <= sdata_d;
         reset_q <= reset_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         pcm_q   <= pcm_d;
      end
   end

   assign count_reg = count_q;
   assign SYNC      = sync_q;
   assign SDATA_OUT = sdata_q;
   assign RESET     = reset_q;

endmodule

// File: tb/tb_ac97_controller.sv
// Directed self-checking bench for ac97_controller: reset, frame timing, slot
// payloads, mid-frame input change, mid-frame reset and ignored inputs.
module tb_ac97_controller;

   logic        BIT_CLK = 1'b0;
   logic        SYSTEM_RESET;
   logic        SYSCLK;
   logic [19:0] PCM_LR;
   logic [19:0] CMD_ADDR;
   logic [19:0] CMD_DATA;
   logic        SDATA_IN;
   logic [7:0]  count_reg;
   logic        SYNC;
   logic        SDATA_OUT;
   logic        RESET;

   int n_total = 0;
   int n_pass  = 0;
   bit toggle_sdin = 1'b0;

   ac97_controller dut (
      .BIT_CLK      (BIT_CLK),
      .SYSTEM_RESET (SYSTEM_RESET),
      .SYSCLK       (SYSCLK),
      .PCM_LR       (PCM_LR),
      .CMD_ADDR     (CMD_ADDR),
      .CMD_DATA     (CMD_DATA),
      .SDATA_IN     (SDATA_IN),
      .count_reg    (count_reg),
      .SYNC         (SYNC),
      .SDATA_OUT    (SDATA_OUT),
      .RESET        (RESET)
   );

   always #5 BIT_CLK = ~BIT_CLK;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total = n_total + 1;
      assert (obs === exp) n_pass = n_pass + 1;
      else $error("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
   endtask

   task automatic tick();
      @(posedge BIT_CLK);
      #1;
      if (toggle_sdin) SDATA_IN = 1'($urandom_range(0, 1));
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_count"}, 32'(count_reg), 32'd255);
      check({tag, "_sync"},  32'(SYNC),      32'd0);
      check({tag, "_sdata"}, 32'(SDATA_OUT), 32'd0);
      check({tag, "_reset"}, 32'(RESET),     32'd0);
   endtask

   // Runs one full frame from count 0, comparing against a concatenated frame image.
   // At count chg_at, PCM_LR is switched to p_new (takes effect in the next frame).
   task automatic run_frame(input string tag, input logic [19:0] a, input logic [19:0] d,
                            input logic [19:0] p, input int chg_at, input logic [19:0] p_new);
      logic [255:0] f;
      f = {16'b1111_1000_0000_0000, a, d, p, p, 160'd0};
      for (int n = 0; n < 256; n++) begin
         tick();
         check({tag, "_count"}, 32'(count_reg), 32'(n));
         check({tag, "_sync"},  32'(SYNC),      (n < 16) ? 32'd1 : 32'd0);
         check({tag, "_sdata"}, 32'(SDATA_OUT), 32'(f[255 - n]));
         check({tag, "_reset"}, 32'(RESET),     32'd1);
         if (n == chg_at) PCM_LR = p_new;
      end
   endtask

   initial begin
      SYSTEM_RESET = 1'b1;
      SYSCLK       = 1'b0;
      PCM_LR       = 20'h00000;
      CMD_ADDR     = 20'h00000;
      CMD_DATA     = 20'h00000;
      SDATA_IN     = 1'b0;

      for (int i = 0; i < 4; i++) tick();
      check_reset_state("rst");

      // Frame 1: payload; at its last bit, PCM goes to zero for frame 2.
      CMD_ADDR     = 20'h02000;
      CMD_DATA     = 20'h80000;
      PCM_LR       = 20'hA5A5A;
      SYSTEM_RESET = 1'b0;
      run_frame("f1", 20'h02000, 20'h80000, 20'hA5A5A, 255, 20'h00000);

      // Frame 2: PCM changes mid-frame at bit 60; slots 3/4 must stay zero.
      run_frame("f2", 20'h02000, 20'h80000, 20'h00000, 60, 20'hFFFFF);

      // Frame 3: new PCM visible; SDATA_IN toggles randomly with no effect.
      toggle_sdin = 1'b1;
      run_frame("f3", 20'h02000, 20'h80000, 20'hFFFFF, -1, 20'h00000);
      toggle_sdin = 1'b0;
      SDATA_IN    = 1'b0;

      // Mid-frame reset at count 100, held for two edges.
      CMD_ADDR = 20'h8F000;
      CMD_DATA = 20'h12340;
      PCM_LR   = 20'h7FFFF;
      for (int n = 0; n <= 100; n++) tick();
      check("pre_mrst_count", 32'(count_reg), 32'd100);
      SYSTEM_RESET = 1'b1;
      tick();
      check_reset_state("mrst1");
      tick();
      check_reset_state("mrst2");
      SYSTEM_RESET = 1'b0;
      run_frame("f4", 20'h8F000, 20'h12340, 20'h7FFFF, -1, 20'h00000);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/ac97_controller.md
Name: ac97_controller

Overview:
AC'97 link-layer serializer that drives an AC'97 audio codec. It generates the 256-bit output frame (SYNC, SDATA_OUT) from a 20-bit command address, a 20-bit command data word and a 20-bit PCM sample. It also drives the codec's active-low reset. It sits between the synthesizer's sample/command logic and the codec pins.

Parameters:
None. Frame length is fixed at 256 bits and the slot width at 20 bits.

Ports:
BIT_CLK  input  1  12.288 MHz bit clock from the codec; the single clock of the block; all logic on its rising edge
SYSTEM_RESET  input  1  synchronous, active-high reset, sampled on BIT_CLK rising edge
SYSCLK  input  1  system clock; unused inside the block; kept for top-level interface compatibility
PCM_LR  input  20  PCM sample, two's complement, sent to both left (slot 3) and right (slot 4)
CMD_ADDR  input  20  slot 1 command address word (bit19 = read request, bits 18:12 = register index, bits 11:0 = 0)
CMD_DATA  input  20  slot 2 command data word (bits 19:4 = data, bits 3:0 = 0)
SDATA_IN  input  1  codec serial input; ignored (no status/input-slot capture)
count_reg  output  8  current frame bit position 0..255
SYNC  output  1  frame sync to codec
SDATA_OUT  output  1  serial data to codec, MSB first
RESET  output  1  codec reset, active low

Behaviour:
- Clock/reset: one clock (BIT_CLK). Reset is synchronous and active-high (SYSTEM_RESET). All outputs are registered.
- Reset values while SYSTEM_RESET=1 at a rising edge:
  - count_reg=255
  - SYNC=0
  - SDATA_OUT=0
  - RESET=0
  - latched frame words = 0
- RESET output: after reset, RESET is 1 from the first rising edge with SYSTEM_RESET=0. It returns to 0 on any later edge with SYSTEM_RESET=1.
- Bit counter: count_reg increments by 1 on every non-reset edge and wraps 255 -> 0. The first edge after reset release gives count_reg=0, which is the start of frame.
- Input latch: on the edge where count_reg goes 255 -> 0, CMD_ADDR, CMD_DATA and PCM_LR are captured into internal frame registers. The whole frame uses these latched values. Changes to the inputs mid-frame take effect in the next frame only.
- Output alignment: in the cycle where count_reg = n, SYNC and SDATA_OUT present frame bit n. Both are updated on the same edge as count_reg.
- SYNC: 1 for n = 0..15 and 0 for n = 16..255, giving 16 high cycles per 256.
- Frame bit n on SDATA_OUT:
  - n 0..15: tag[15-n]. Tag = 16'b1111_1000_0000_0000: frame valid, slots 1, 2, 3 and 4 valid, all others invalid, codec ID 00.
  - n 16..35: latched CMD_ADDR[35-n].
  - n 36..55: latched CMD_DATA[55-n].
  - n 56..75: latched PCM_LR[75-n] (left).
  - n 76..95: latched PCM_LR[95-n] (right).
  - n 96..255: 0.
- Reset mid-frame: takes effect on the next edge. The outputs return to their reset values. The frame restarts at bit 0 on the first edge after release, and the inputs are re-latched then.
- SDATA_IN and SYSCLK have no effect on any output.

Test Plan:
- Reset: hold SYSTEM_RESET=1 for 4 edges -> count_reg=255, SYNC=0, SDATA_OUT=0, RESET=0. Release -> next edge count_reg=0, SYNC=1, SDATA_OUT=1, RESET=1.
- Frame timing: run 512 edges after reset -> count_reg runs 0..255 twice with wrap 255->0. SYNC is high exactly at count_reg 0..15 of each frame. Tag bits read serially 1111_1000_0000_0000.
- Slot payload: CMD_ADDR=20'h02000, CMD_DATA=20'h80000, PCM_LR=20'hA5A5A -> bits 16..35 serialize 0x02000 MSB first, bits 36..55 give 0x80000, bits 56..75 and 76..95 each give 0xA5A5A, bits 96..255 are all 0.
- Mid-frame change: change PCM_LR from 20'h00000 to 20'hFFFFF at count_reg=60 -> current frame slots 3/4 remain all 0. The next frame's bits 56..95 are all 1.
- Mid-frame reset: assert SYSTEM_RESET at count_reg=100 for 2 edges -> outputs return to reset values. After release the frame restarts at count_reg=0 with SYNC=1.
- Ignored inputs: toggle SDATA_IN randomly and hold SYSCLK constant -> SYNC, SDATA_OUT and count_reg are identical to the run with SDATA_IN=0.
